// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default widths, the
// access-FSM state encoding and the address range check.
package dmem_responder_pkg;

  localparam int DEF_DATA_W = 16;  // data word width
  localparam int DEF_ADDR_W = 8;   // word-address bits backed by storage
  localparam int CPU_ADDR_W = 16;  // width of the ALU-result address bus
  localparam int CNT_W      = 4;   // latency counter width (LATENCY <= 15)

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  // True when the CPU address has any bit set above the storage depth.
  function automatic logic addr_out_of_range(input logic [CPU_ADDR_W-1:0] a,
                                             input int unsigned aw);
    return (a >> aw) != '0;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Ports:
//   clk    rising-edge clock
//   we     write enable
//   addr   word address (shared by read and write)
//   wdata  write data
//   rdata  registered read data (contents of addr at the last edge)
// Contents are deliberately not reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Storage write and registered read (read returns the pre-write word).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the 16-bit CPU. Serves LW/SW requests with a fixed
// access latency, stalling the pipeline until the access completes, and
// accepts preload writes when the CPU side is idle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mem_read, mem_write      load / store request (held stable while stalled)
//   addr, wdata              word address (ALU result) and store data
//   rdata, rdata_valid       load data and its 1-cycle valid pulse
//   stall                    hold the pipeline
//   err                      1-cycle pulse: access rejected
//   init_we/addr/data        preload write port
//   init_ack                 preload accepted this cycle (combinational)
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [CPU_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_valid,
  output logic                  stall,
  output logic                  err,
  input  logic                  init_we,
  input  logic [ADDR_W-1:0]     init_addr,
  input  logic [DATA_W-1:0]     init_data,
  output logic                  init_ack
);

  // The request cycle itself is the first stall cycle, so WAIT covers the rest.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_read_q, op_write_q, op_err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rdata_valid_q, err_q;
  logic [DATA_W-1:0] rdata_hold_q;

  logic              req_s, req_err_s, access_end_s;
  logic              cur_read_s, cur_write_s, cur_err_s;
  logic [ADDR_W-1:0] cur_addr_s;
  logic [DATA_W-1:0] cur_wdata_s;
  logic              arr_we_s;
  logic [ADDR_W-1:0] arr_addr_s;
  logic [DATA_W-1:0] arr_wdata_s;
  logic [DATA_W-1:0] arr_rdata_s;

  assign req_s     = mem_read | mem_write;
  assign req_err_s = (mem_read & mem_write) | addr_out_of_range(addr, ADDR_W);

  // Next-state, counter, stall and preload arbitration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall       = 1'b0;
    init_ack    = 1'b0;
    cur_read_s  = op_read_q;
    cur_write_s = op_write_q;
    cur_err_s   = op_err_q;
    cur_addr_s  = addr_q;
    cur_wdata_s = wdata_q;
    case (state_q)
      MEM_IDLE: begin
        // With LATENCY=1 the access completes straight from the live inputs.
        cur_read_s  = mem_read;
        cur_write_s = mem_write;
        cur_err_s   = req_err_s;
        cur_addr_s  = addr[ADDR_W-1:0];
        cur_wdata_s = wdata;
        if (req_s) begin
          stall   = 1'b1;
          cnt_d   = CNT_LOAD;
          state_d = (LATENCY > 1) ? MEM_WAIT : MEM_DONE;
        end else begin
          init_ack = init_we & ~rst;
        end
      end
      MEM_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = MEM_DONE;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      MEM_DONE: begin
        // Request lines still belong to the finishing instruction.
        state_d = MEM_IDLE;
      end
      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  // DONE is always left after one cycle, so state_d==DONE marks the edge in.
  assign access_end_s = (state_d == MEM_DONE);

  // RAM port mux: the completing CPU access has priority over preload.
  always_comb begin
    arr_we_s    = 1'b0;
    arr_addr_s  = cur_addr_s;
    arr_wdata_s = cur_wdata_s;
    if (access_end_s) begin
      arr_we_s = cur_write_s & ~cur_err_s & ~rst;
    end else if (init_ack) begin
      arr_we_s    = 1'b1;
      arr_addr_s  = init_addr;
      arr_wdata_s = init_data;
    end else begin
      arr_we_s = 1'b0;
    end
  end

  dmem_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (arr_we_s),
    .addr (arr_addr_s),
    .wdata(arr_wdata_s),
    .rdata(arr_rdata_s)
  );

  // FSM state, request latch and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= MEM_IDLE;
      cnt_q         <= '0;
      op_read_q     <= 1'b0;
      op_write_q    <= 1'b0;
      op_err_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      rdata_hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == MEM_IDLE && req_s) begin
        op_read_q  <= mem_read;
        op_write_q <= mem_write;
        op_err_q   <= req_err_s;
        addr_q     <= addr[ADDR_W-1:0];
        wdata_q    <= wdata;
      end
      rdata_valid_q <= access_end_s & cur_read_s & ~cur_err_s;
      err_q         <= access_end_s & cur_err_s;
      // Capture the RAM word after its valid cycle so rdata holds it.
      if (rdata_valid_q) begin
        rdata_hold_q <= arr_rdata_s;
      end
    end
  end

  // The RAM's registered output is the load data during the valid pulse.
  assign rdata       = rdata_valid_q ? arr_rdata_s : rdata_hold_q;
  assign rdata_valid = rdata_valid_q;
  assign err         = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] wd;
    logic        e_err;
    logic        e_val;
    logic [15:0] e_rd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_read_a    [2];
  logic        mem_write_a   [2];
  logic [15:0] addr_a        [2];
  logic [15:0] wdata_a       [2];
  logic [15:0] rdata_a       [2];
  logic        rdata_valid_a [2];
  logic        stall_a       [2];
  logic        err_a         [2];
  logic        init_we_a     [2];
  logic [7:0]  init_addr_a   [2];
  logic [15:0] init_data_a   [2];
  logic        init_ack_a    [2];

  int n_checks;
  int n_fail;
  logic [15:0] mem_m  [2][256];
  logic [15:0] last_m [2];
  vec_t tbl [10];

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(LAT0)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read_a[0]), .mem_write(mem_write_a[0]),
    .addr(addr_a[0]), .wdata(wdata_a[0]), .rdata(rdata_a[0]),
    .rdata_valid(rdata_valid_a[0]), .stall(stall_a[0]), .err(err_a[0]),
    .init_we(init_we_a[0]), .init_addr(init_addr_a[0]), .init_data(init_data_a[0]),
    .init_ack(init_ack_a[0]));

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(LAT1)) dut_lat1 (
    .clk(clk), .rst(rst), .mem_read(mem_read_a[1]), .mem_write(mem_write_a[1]),
    .addr(addr_a[1]), .wdata(wdata_a[1]), .rdata(rdata_a[1]),
    .rdata_valid(rdata_valid_a[1]), .stall(stall_a[1]), .err(err_a[1]),
    .init_we(init_we_a[1]), .init_addr(init_addr_a[1]), .init_data(init_data_a[1]),
    .init_ack(init_ack_a[1]));

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: plain memory array plus last loaded word.
  task automatic model_step(input int s, input logic rd, input logic wr,
                            input logic [15:0] a, input logic [15:0] wd,
                            output logic e_err, output logic e_val, output logic [15:0] e_rd);
    e_err = (rd && wr) || (a > 16'd255);
    e_val = rd && !e_err;
    if (!e_err && wr) mem_m[s][a[7:0]] = wd;
    if (e_val) last_m[s] = mem_m[s][a[7:0]];
    e_rd = last_m[s];
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 with it idle.
  task automatic access(input int s, input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic e_err, input logic e_val, input logic [15:0] e_rd,
                        input string nm);
    int lat;
    lat = (s == 0) ? LAT0 : LAT1;
    mem_read_a[s]  = rd;
    mem_write_a[s] = wr;
    addr_a[s]      = a;
    wdata_a[s]     = wd;
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      chk1({nm, " stall"}, stall_a[s], 1'b1);
      chk1({nm, " early valid"}, rdata_valid_a[s], 1'b0);
      chk1({nm, " early err"}, err_a[s], 1'b0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1({nm, " done stall"}, stall_a[s], 1'b0);
    chk1({nm, " valid"}, rdata_valid_a[s], e_val);
    chk1({nm, " err"}, err_a[s], e_err);
    chk16({nm, " rdata"}, rdata_a[s], e_rd);
    @(posedge clk); #1;
    mem_read_a[s]  = 1'b0;
    mem_write_a[s] = 1'b0;
  endtask

  task automatic model_access(input int s, input logic rd, input logic wr,
                              input logic [15:0] a, input logic [15:0] wd, input string nm);
    logic e_err, e_val;
    logic [15:0] e_rd;
    model_step(s, rd, wr, a, wd, e_err, e_val, e_rd);
    access(s, rd, wr, a, wd, e_err, e_val, e_rd, nm);
  endtask

  task automatic preload(input int s, input logic [7:0] a, input logic [15:0] d, input string nm);
    init_we_a[s]   = 1'b1;
    init_addr_a[s] = a;
    init_data_a[s] = d;
    @(negedge clk);
    chk1({nm, " ack"}, init_ack_a[s], 1'b1);
    @(posedge clk); #1;
    init_we_a[s] = 1'b0;
    mem_m[s][a] = d;
  endtask

  task automatic rand_op(input string nm);
    logic rd, wr;
    logic [15:0] a, wd;
    int op;
    op = $urandom_range(0, 3);
    rd = (op != 2);
    wr = (op >= 2);
    if ($urandom_range(0, 7) == 0) a = 16'(1 << $urandom_range(8, 15));
    else a = 16'($urandom_range(0, 255));
    wd = 16'($urandom);
    model_access(0, rd, wr, a, wd, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic e_err, e_val;
    logic [15:0] e_rd;
    n_checks = 0;
    n_fail   = 0;
    tbl[0] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
    tbl[1] = '{1'b0, 1'b1, 16'h0003, 16'h1234, 1'b0, 1'b0, 16'hBEEF};
    tbl[2] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 1'b1, 16'h1234};
    tbl[3] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h1234};
    tbl[4] = '{1'b1, 1'b1, 16'h0007, 16'h5555, 1'b1, 1'b0, 16'h1234};
    tbl[5] = '{1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0, 1'b1, 16'h00AA};
    tbl[6] = '{1'b0, 1'b1, 16'h00FF, 16'hA5A5, 1'b0, 1'b0, 16'h00AA};
    tbl[7] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'hA5A5};
    tbl[8] = '{1'b0, 1'b1, 16'h8000, 16'h0000, 1'b1, 1'b0, 16'hA5A5};
    tbl[9] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0F0F};

    for (int s = 0; s < 2; s++) begin
      mem_read_a[s] = 1'b0; mem_write_a[s] = 1'b0; addr_a[s] = 16'h0000;
      wdata_a[s] = 16'h0000; init_we_a[s] = 1'b0; init_addr_a[s] = 8'h00;
      init_data_a[s] = 16'h0000; last_m[s] = 16'h0000;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk1($sformatf("reset stall%0d", s), stall_a[s], 1'b0);
      chk1($sformatf("reset init_ack%0d", s), init_ack_a[s], 1'b0);
      chk1($sformatf("reset valid%0d", s), rdata_valid_a[s], 1'b0);
      chk1($sformatf("reset err%0d", s), err_a[s], 1'b0);
      chk16($sformatf("reset rdata%0d", s), rdata_a[s], 16'h0000);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 256; i++) preload(0, 8'(i), 16'($urandom), "fill");
    preload(0, 8'd5, 16'hBEEF, "pre5");
    preload(0, 8'd7, 16'h00AA, "pre7");
    preload(0, 8'd0, 16'h0F0F, "pre0");
    preload(0, 8'd9, 16'h0909, "pre9");

    // Directed table: loads, back-to-back store/load, range and rd&wr errors.
    for (int i = 0; i < 10; i++) begin
      model_step(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, e_err, e_val, e_rd);
      access(0, tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd,
             tbl[i].e_err, tbl[i].e_val, tbl[i].e_rd, $sformatf("tbl%0d", i));
    end

    // Reset during WAIT of a store: store dropped, back to IDLE.
    mem_write_a[0] = 1'b1; addr_a[0] = 16'd9; wdata_a[0] = 16'hFFFF;
    @(negedge clk);
    chk1("rstmid stall idle", stall_a[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk1("rstmid stall wait", stall_a[0], 1'b1);
    @(posedge clk); #1;
    rst = 1'b0; mem_write_a[0] = 1'b0;
    last_m[0] = 16'h0000; last_m[1] = 16'h0000;
    @(negedge clk);
    chk1("rstmid stall", stall_a[0], 1'b0);
    chk1("rstmid valid", rdata_valid_a[0], 1'b0);
    chk1("rstmid err", err_a[0], 1'b0);
    chk16("rstmid rdata", rdata_a[0], 16'h0000);
    @(posedge clk); #1;
    model_step(0, 1'b1, 1'b0, 16'd9, 16'h0000, e_err, e_val, e_rd);
    access(0, 1'b1, 1'b0, 16'd9, 16'h0000, 1'b0, 1'b1, 16'h0909, "rstmid lw9");

    // Preload attempted during a load: refused until IDLE, then lands.
    model_step(0, 1'b1, 1'b0, 16'd20, 16'h0000, e_err, e_val, e_rd);
    mem_read_a[0] = 1'b1; addr_a[0] = 16'd20;
    init_we_a[0] = 1'b1; init_addr_a[0] = 8'd21; init_data_a[0] = 16'h7777;
    for (int k = 0; k < LAT0; k++) begin
      @(negedge clk);
      chk1("initbusy ack", init_ack_a[0], 1'b0);
      chk1("initbusy stall", stall_a[0], 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("initdone ack", init_ack_a[0], 1'b0);
    chk1("initdone valid", rdata_valid_a[0], 1'b1);
    chk16("initdone rdata", rdata_a[0], e_rd);
    @(posedge clk); #1;
    mem_read_a[0] = 1'b0;
    @(negedge clk);
    chk1("initidle ack", init_ack_a[0], 1'b1);
    @(posedge clk); #1;
    init_we_a[0] = 1'b0;
    mem_m[0][21] = 16'h7777;
    model_step(0, 1'b1, 1'b0, 16'd21, 16'h0000, e_err, e_val, e_rd);
    access(0, 1'b1, 1'b0, 16'd21, 16'h0000, 1'b0, 1'b1, 16'h7777, "initlate lw21");

    // Randomized traffic against the model, with occasional preloads.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0)
        preload(0, 8'($urandom_range(0, 255)), 16'($urandom), $sformatf("rpre%0d", i));
      rand_op($sformatf("rnd%0d", i));
    end

    // LATENCY=1 build: single stall cycle per access.
    preload(1, 8'd2, 16'h2222, "l1 pre2");
    model_step(1, 1'b1, 1'b0, 16'd2, 16'h0000, e_err, e_val, e_rd);
    access(1, 1'b1, 1'b0, 16'd2, 16'h0000, 1'b0, 1'b1, 16'h2222, "l1 lw2");
    model_step(1, 1'b0, 1'b1, 16'd4, 16'h4444, e_err, e_val, e_rd);
    access(1, 1'b0, 1'b1, 16'd4, 16'h4444, 1'b0, 1'b0, 16'h2222, "l1 sw4");
    model_step(1, 1'b1, 1'b0, 16'd4, 16'h0000, e_err, e_val, e_rd);
    access(1, 1'b1, 1'b0, 16'd4, 16'h0000, 1'b0, 1'b1, 16'h4444, "l1 lw4");
    model_step(1, 1'b1, 1'b0, 16'h0200, 16'h0000, e_err, e_val, e_rd);
    access(1, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 1'b0, 16'h4444, "l1 lwbad");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
